ksa_swap_fsm: RTL

//  RC4 key-scheduling (KSA) swap stage. Runs after the S-array init stage has

---
 rtl/ksa_swap_fsm_if.sv | 24 ++
 rtl/ksa_swap_fsm.sv | 148 ++++++++++++++
 2 files changed

// File: rtl/ksa_swap_fsm_if.sv
// Signal bundle between the RC4 KSA swap stage and its S RAM / sequencer.
// slave = the swap stage; master = the RAM and control side that drives it.
interface ksa_swap_fsm_if #(
  parameter int KEY_W = 24
);
  logic             start;
  logic [KEY_W-1:0] secret_key;
  logic [7:0]       address;
  logic [7:0]       data;
  logic             wren;
  logic [7:0]       q;
  logic             busy;
  logic             done;

  modport slave (
    input  start, secret_key, q,
    output address, data, wren, busy, done
  );

  modport master (
    output start, secret_key, q,
    input  address, data, wren, busy, done
  );
endinterface

// File: rtl/ksa_swap_fsm.sv
// RC4 key-scheduling swap stage: j += s[i] + key[i mod KEY_LEN]; swap s[i], s[j].
// Optional feature macro KSA_SKIP_SELF_SWAP_EN skips the read/write half when j == i.
module ksa_swap_fsm #(
  parameter int KEY_LEN = 3,
  parameter int KEY_W   = 8 * KEY_LEN
) (
  input  logic          clk,
  input  logic          reset_n,
  ksa_swap_fsm_if.slave bus
);
  localparam int KIDX_W = (KEY_LEN > 1) ? $clog2(KEY_LEN) : 1;

  typedef enum logic [3:0] {
    IDLE, RD_I, WT_I, CAP_I, RD_J, WT_J, CAP_J, WR_I, WR_J, DONE
  } state_t;

  state_t            state_q, state_d;
  logic [7:0]        i_q, i_d, j_q, j_d;
  logic [7:0]        si_q, si_d, sj_q, sj_d;
  logic [KIDX_W-1:0] kidx_q, kidx_d, kidx_inc;
  logic [KEY_W-1:0]  key_q, key_d;
  logic [7:0]        addr_q, addr_d, data_q, data_d;
  logic              wren_q, wren_d, busy_q, busy_d, done_q, done_d;
  logic [7:0]        key_byte [KEY_LEN];
  logic [7:0]        cur_key_byte;

  // Byte 0 of the key sits in the most significant byte of the latched key.
  genvar gi;
  generate
    for (gi = 0; gi < KEY_LEN; gi++) begin : g_key_bytes
      assign key_byte[gi] = key_q[KEY_W-1-8*gi -: 8];
    end
  endgenerate

  assign cur_key_byte = key_byte[kidx_q];
  assign kidx_inc     = (kidx_q == KIDX_W'(KEY_LEN - 1)) ? '0 : kidx_q + 1'b1;

  always_comb begin
    state_d = state_q;
    i_d     = i_q;
    j_d     = j_q;
    si_d    = si_q;
    sj_d    = sj_q;
    kidx_d  = kidx_q;
    key_d   = key_q;
    unique case (state_q)
      IDLE, DONE: begin
        if (bus.start) begin
          key_d   = bus.secret_key;
          i_d     = '0;
          j_d     = '0;
          kidx_d  = '0;
          state_d = RD_I;
        end
      end
      RD_I:  state_d = WT_I;
      WT_I:  state_d = CAP_I;
      CAP_I: begin
        si_d    = bus.q;
        j_d     = j_q + bus.q + cur_key_byte;
        state_d = RD_J;
      end
      RD_J: begin
`ifdef KSA_SKIP_SELF_SWAP_EN
        if (j_q == i_q) begin
          i_d     = i_q + 8'd1;
          kidx_d  = kidx_inc;
          state_d = (i_q == 8'hFF) ? DONE : RD_I;
        end else begin
          state_d = WT_J;
        end
`else
        state_d = WT_J;
`endif
      end
      WT_J:  state_d = CAP_J;
      CAP_J: begin
        sj_d    = bus.q;
        state_d = WR_I;
      end
      WR_I:  state_d = WR_J;
      WR_J: begin
        i_d     = i_q + 8'd1;
        kidx_d  = kidx_inc;
        state_d = (i_q == 8'hFF) ? DONE : RD_I;
      end
      default: state_d = IDLE;
    endcase

    // Outputs are decoded from the next state so the registered bus lines up with the state.
    addr_d = addr_q;
    data_d = data_q;
    wren_d = 1'b0;
    busy_d = (state_d != IDLE) && (state_d != DONE);
    done_d = (state_d == DONE);
    case (state_d)
      RD_I, WT_I, CAP_I: addr_d = i_d;
      RD_J, WT_J, CAP_J: addr_d = j_d;
      WR_I: begin
        addr_d = i_d;
        data_d = sj_d;
        wren_d = 1'b1;
      end
      WR_J: begin
        addr_d = j_d;
        data_d = si_d;
        wren_d = 1'b1;
      end
      default: begin end
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      i_q     <= '0;
      j_q     <= '0;
      si_q    <= '0;
      sj_q    <= '0;
      kidx_q  <= '0;
      key_q   <= '0;
      addr_q  <= '0;
      data_q  <= '0;
      wren_q  <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      i_q     <= i_d;
      j_q     <= j_d;
      si_q    <= si_d;
      sj_q    <= sj_d;
      kidx_q  <= kidx_d;
      key_q   <= key_d;
      addr_q  <= addr_d;
      data_q  <= data_d;
      wren_q  <= wren_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign bus.address = addr_q;
  assign bus.data    = data_q;
  assign bus.wren    = wren_q;
  assign bus.busy    = busy_q;
  assign bus.done    = done_q;
endmodule
